// File: rtl/gp_reg_file_32x32_if.sv
// Decode/writeback-facing bus of the general-purpose register file.
// The master drives the indices and write data, and the slave returns the two read values.
interface gp_reg_file_32x32_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic              wr_en;
    logic [IDX_W-1:0]  rd_reg_index_1;
    logic [IDX_W-1:0]  rd_reg_index_2;
    logic [IDX_W-1:0]  wr_reg_index;
    logic [DATA_W-1:0] wr_reg_data;
    logic [DATA_W-1:0] reg_data_1;
    logic [DATA_W-1:0] reg_data_2;

    modport master (
        output wr_en, rd_reg_index_1, rd_reg_index_2, wr_reg_index, wr_reg_data,
        input  reg_data_1, reg_data_2
    );

    modport slave (
        input  wr_en, rd_reg_index_1, rd_reg_index_2, wr_reg_index, wr_reg_data,
        output reg_data_1, reg_data_2
    );
endinterface

// File: rtl/gp_reg_file_32x32.sv
// 32x32 integer register file: two combinational read ports and one clocked write port.
// Register 0 is hardwired to zero.
module gp_reg_file_32x32 #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic               clk,
    input  logic               rst,
    gp_reg_file_32x32_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REGS);

    // Index 0 has no storage at all, so it reads 0 even before the first reset.
    logic [DATA_W-1:0] r_regs [1:NUM_REGS-1];
    logic [DATA_W-1:0] w_rd_data_1;
    logic [DATA_W-1:0] w_rd_data_2;

    always_ff @(posedge clk) begin
        for (int k = 1; k < NUM_REGS; k++) begin
            if (rst) begin
                r_regs[k] <= '0;
            end else if (bus.wr_en && (bus.wr_reg_index == IDX_W'(k))) begin
                r_regs[k] <= bus.wr_reg_data;
            end
        end
    end

    // Read muxes see only the stored state, so a pending write is not forwarded.
    always_comb begin
        w_rd_data_1 = '0;
        w_rd_data_2 = '0;
        for (int k = 1; k < NUM_REGS; k++) begin
            if (bus.rd_reg_index_1 == IDX_W'(k)) begin
                w_rd_data_1 = r_regs[k];
            end
            if (bus.rd_reg_index_2 == IDX_W'(k)) begin
                w_rd_data_2 = r_regs[k];
            end
        end
    end

    assign bus.reg_data_1 = w_rd_data_1;
    assign bus.reg_data_2 = w_rd_data_2;
endmodule

// File: tb/tb_gp_reg_file_32x32.sv
// Self-checking bench for gp_reg_file_32x32.
// It compares the directed scenarios and random traffic against an array model of the register file.
module tb_gp_reg_file_32x32;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    // Reference state: a plain array plus a flag for whether reset has defined it yet.
    logic [31:0] model [32];
    bit          model_known = 1'b0;

    gp_reg_file_32x32_if #(.DATA_W(32), .NUM_REGS(32)) bus ();

    gp_reg_file_32x32 #(.DATA_W(32), .NUM_REGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        return model[idx];
    endfunction

    function automatic void model_edge(input bit r, input bit we, input logic [4:0] idx, input logic [31:0] d);
        if (r) begin
            foreach (model[i]) model[i] = 32'd0;
            model_known = 1'b1;
        end else if (we && idx != 5'd0) begin
            model[idx] = d;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] idx, input logic [31:0] d);
        bus.wr_en        = 1'b1;
        bus.wr_reg_index = idx;
        bus.wr_reg_data  = d;
        tick();
        model_edge(1'b0, 1'b1, idx, d);
        bus.wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        model_edge(1'b1, 1'b0, 5'd0, 32'd0);
        rst = 1'b0;
    endtask

    task automatic test_pre_reset_zero();
        bus.rd_reg_index_1 = 5'd0;
        bus.rd_reg_index_2 = 5'd0;
        #1;
        total++;
        if (bus.reg_data_1 !== 32'd0 || bus.reg_data_2 !== 32'd0) begin
            bad++;
            $display("FAIL pre_reset_r0: got %h/%h want 0/0", bus.reg_data_1, bus.reg_data_2);
        end
    endtask

    task automatic test_reset();
        do_reset();
        bus.rd_reg_index_1 = 5'd10;
        bus.rd_reg_index_2 = 5'd15;
        #1;
        total++;
        if (bus.reg_data_1 !== 32'd0 || bus.reg_data_2 !== 32'd0) begin
            bad++;
            $display("FAIL reset_10_15: got %h/%h want 0/0", bus.reg_data_1, bus.reg_data_2);
        end
        for (int i = 0; i < 32; i++) begin
            bus.rd_reg_index_1 = 5'(i);
            bus.rd_reg_index_2 = 5'(31 - i);
            #1;
            total++;
            if (bus.reg_data_1 !== 32'd0 || bus.reg_data_2 !== 32'd0) begin
                bad++;
                $display("FAIL reset_all idx=%0d: got %h/%h want 0/0", i, bus.reg_data_1, bus.reg_data_2);
            end
        end
    endtask

    task automatic test_write_read();
        do_write(5'd5, 32'd1234);
        bus.rd_reg_index_1 = 5'd5;
        #1;
        total++;
        if (bus.reg_data_1 !== 32'd1234) begin
            bad++;
            $display("FAIL write_read_r5: got %0d want 1234", bus.reg_data_1);
        end
        repeat (4) tick();
        total++;
        if (bus.reg_data_1 !== 32'd1234) begin
            bad++;
            $display("FAIL hold_r5: got %0d want 1234", bus.reg_data_1);
        end
    endtask

    task automatic test_reg0();
        do_write(5'd0, 32'd2431);
        bus.rd_reg_index_1 = 5'd0;
        bus.rd_reg_index_2 = 5'd0;
        #1;
        total++;
        if (bus.reg_data_1 !== 32'd0 || bus.reg_data_2 !== 32'd0) begin
            bad++;
            $display("FAIL reg0_write: got %h/%h want 0/0", bus.reg_data_1, bus.reg_data_2);
        end
    endtask

    task automatic test_write_disabled();
        bus.wr_en        = 1'b0;
        bus.wr_reg_index = 5'd7;
        bus.wr_reg_data  = 32'hDEADBEEF;
        repeat (3) tick();
        bus.rd_reg_index_1 = 5'd7;
        bus.rd_reg_index_2 = 5'd7;
        #1;
        total++;
        if (bus.reg_data_1 !== 32'd0 || bus.reg_data_2 !== 32'd0) begin
            bad++;
            $display("FAIL wr_disabled_r7: got %h/%h want 0/0", bus.reg_data_1, bus.reg_data_2);
        end
    endtask

    task automatic test_reset_priority();
        do_write(5'd3, 32'd55);
        bus.rd_reg_index_1 = 5'd3;
        #1;
        total++;
        if (bus.reg_data_1 !== 32'd55) begin
            bad++;
            $display("FAIL pre_rst_r3: got %0d want 55", bus.reg_data_1);
        end
        rst              = 1'b1;
        bus.wr_en        = 1'b1;
        bus.wr_reg_index = 5'd3;
        bus.wr_reg_data  = 32'd99;
        tick();
        model_edge(1'b1, 1'b1, 5'd3, 32'd99);
        rst       = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_reg_index_1 = 5'd3;
        bus.rd_reg_index_2 = 5'd5;
        #1;
        total++;
        if (bus.reg_data_1 !== 32'd0 || bus.reg_data_2 !== 32'd0) begin
            bad++;
            $display("FAIL rst_priority r3/r5: got %0d/%0d want 0/0", bus.reg_data_1, bus.reg_data_2);
        end
    endtask

    task automatic test_dual_port_no_bypass();
        do_write(5'd31, 32'hA5A5A5A5);
        bus.rd_reg_index_1 = 5'd31;
        bus.rd_reg_index_2 = 5'd31;
        #1;
        total++;
        if (bus.reg_data_1 !== 32'hA5A5A5A5 || bus.reg_data_2 !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL dual_r31: got %h/%h want a5a5a5a5", bus.reg_data_1, bus.reg_data_2);
        end
        bus.wr_en        = 1'b1;
        bus.wr_reg_index = 5'd31;
        bus.wr_reg_data  = 32'h1;
        #2;
        total++;
        if (bus.reg_data_1 !== 32'hA5A5A5A5 || bus.reg_data_2 !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL no_bypass_r31: got %h/%h want a5a5a5a5", bus.reg_data_1, bus.reg_data_2);
        end
        tick();
        model_edge(1'b0, 1'b1, 5'd31, 32'h1);
        bus.wr_en = 1'b0;
        total++;
        if (bus.reg_data_1 !== 32'h1 || bus.reg_data_2 !== 32'h1) begin
            bad++;
            $display("FAIL after_edge_r31: got %h/%h want 1", bus.reg_data_1, bus.reg_data_2);
        end
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        bit          r, we;
        logic [4:0]  widx;
        logic [31:0] wdat;
        for (int n = 0; n < 400; n++) begin
            r    = ($urandom_range(0, 59) == 0);
            we   = $urandom_range(0, 1);
            widx = 5'($urandom_range(0, 31));
            wdat = $urandom;
            rst              = r;
            bus.wr_en        = we;
            bus.wr_reg_index = widx;
            bus.wr_reg_data  = wdat;
            // Half the time, read the register being written so that no-bypass is also checked on it.
            bus.rd_reg_index_1 = ($urandom_range(0, 1) == 1) ? widx : 5'($urandom_range(0, 31));
            bus.rd_reg_index_2 = 5'($urandom_range(0, 31));
            #2;
            e1 = model_read(bus.rd_reg_index_1);
            e2 = model_read(bus.rd_reg_index_2);
            total++;
            if (bus.reg_data_1 !== e1 || bus.reg_data_2 !== e2) begin
                bad++;
                $display("FAIL rand_pre n=%0d idx=%0d/%0d: got %h/%h want %h/%h", n,
                         bus.rd_reg_index_1, bus.rd_reg_index_2, bus.reg_data_1, bus.reg_data_2, e1, e2);
            end
            tick();
            model_edge(r, we, widx, wdat);
            rst       = 1'b0;
            bus.wr_en = 1'b0;
            e1 = model_read(bus.rd_reg_index_1);
            e2 = model_read(bus.rd_reg_index_2);
            total++;
            if (bus.reg_data_1 !== e1 || bus.reg_data_2 !== e2) begin
                bad++;
                $display("FAIL rand_post n=%0d idx=%0d/%0d: got %h/%h want %h/%h", n,
                         bus.rd_reg_index_1, bus.rd_reg_index_2, bus.reg_data_1, bus.reg_data_2, e1, e2);
            end
        end
    endtask

    initial begin
        rst                = 1'b0;
        bus.wr_en          = 1'b0;
        bus.wr_reg_index   = 5'd0;
        bus.wr_reg_data    = 32'd0;
        bus.rd_reg_index_1 = 5'd0;
        bus.rd_reg_index_2 = 5'd0;
        foreach (model[i]) model[i] = 32'd0;

        test_pre_reset_zero();
        test_reset();
        test_write_read();
        test_reg0();
        test_write_disabled();
        test_reset_priority();
        test_dual_port_no_bypass();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
